// File: rtl/alu_operand_sequencer.sv
// Collects opcode/A/B words from a valid/ready stream and holds them for the logic unit
// until the downstream side accepts the transaction.
module alu_operand_sequencer #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       op,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [CNT_W-1:0] issue_count,
  output logic             bad_op
);

  typedef enum logic [1:0] {StOp, StA, StB, StIssue} state_e;

  state_e             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               bad_q, bad_d;
  logic               in_acc;
  logic               out_acc;

  // Handshake readiness comes from registered state only.
  assign in_ready  = (state_q != StIssue);
  assign out_valid = (state_q == StIssue);
  assign in_acc    = in_valid && in_ready;
  assign out_acc   = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    bad_d   = bad_q;
    if (flush) begin
      state_d = StOp;
    end else begin
      unique case (state_q)
        StOp: begin
          if (in_acc) begin
            op_d    = in_data[1:0];
            // Malformed opcode words are still used; only the sticky flag records them.
            if (in_data[WIDTH-1:2] != '0) bad_d = 1'b1;
            state_d = StA;
          end
        end
        StA: begin
          if (in_acc) begin
            a_d     = in_data;
            state_d = StB;
          end
        end
        StB: begin
          if (in_acc) begin
            b_d     = in_data;
            state_d = StIssue;
          end
        end
        StIssue: begin
          if (out_acc) begin
            cnt_d   = cnt_q + 1'b1;
            state_d = StOp;
          end
        end
        default: state_d = StOp;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StOp;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      bad_q   <= bad_d;
    end
  end

  assign op          = op_q;
  assign a           = a_q;
  assign b           = b_q;
  assign issue_count = cnt_q;
  assign bad_op      = bad_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Randomised and directed bench for alu_operand_sequencer against a word-collecting model.
module tb_alu_operand_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [1:0]  op;
  logic [15:0] a;
  logic [15:0] b;
  logic [7:0]  issue_count;
  logic        bad_op;

  int n_chk = 0;
  int n_err = 0;

  alu_operand_sequencer #(.WIDTH(16), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .op(op), .a(a), .b(b),
    .issue_count(issue_count), .bad_op(bad_op)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: number of words gathered so far (3 means a complete transaction is waiting).
  int          m_words = 0;
  logic [1:0]  m_op = '0;
  logic [15:0] m_a = '0;
  logic [15:0] m_b = '0;
  int          m_cnt = 0;
  logic        m_bad = 1'b0;
  int          cyc_no = 0;
  int          last_issue = -1;
  bit          tp_en = 1'b0;
  bit          chk_en = 1'b0;

  always @(posedge clk) begin
    cyc_no++;
    if (reset) begin
      m_words = 0; m_op = '0; m_a = '0; m_b = '0; m_cnt = 0; m_bad = 1'b0;
    end else if (flush) begin
      m_words = 0;
    end else if (m_words == 3) begin
      if (out_ready) begin
        m_cnt   = (m_cnt + 1) % 256;
        m_words = 0;
        if (tp_en) begin
          if (last_issue >= 0) check("throughput", cyc_no - last_issue, 4);
          last_issue = cyc_no;
        end
      end
    end else if (in_valid) begin
      if (m_words == 0) begin
        m_op = in_data[1:0];
        if ((in_data >> 2) != 0) m_bad = 1'b1;
      end else if (m_words == 1) begin
        m_a = in_data;
      end else begin
        m_b = in_data;
      end
      m_words++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", in_ready, m_words != 3);
      check("out_valid", out_valid, m_words == 3);
      check("op", op, m_op);
      check("a", a, m_a);
      check("b", b, m_b);
      check("issue_count", issue_count, m_cnt);
      check("bad_op", bad_op, m_bad);
    end
  end

  // Apply inputs at a falling edge and advance to the next falling edge.
  task automatic cyc(input logic v, input logic [15:0] d, input logic rdy,
                     input logic fl, input logic rst);
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    flush     = fl;
    reset     = rst;
    @(negedge clk);
  endtask

  task automatic txn(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2,
                     input logic rdy);
    cyc(1'b1, w0, rdy, 1'b0, 1'b0);
    cyc(1'b1, w1, rdy, 1'b0, 1'b0);
    cyc(1'b1, w2, rdy, 1'b0, 1'b0);
  endtask

  int saved_cnt;

  initial begin
    @(negedge clk);
    cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    chk_en = 1'b1;
    cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    check("lit_reset_ready", in_ready, 1);
    check("lit_reset_cnt", issue_count, 0);

    // Basic issue
    txn(16'h0002, 16'h00F0, 16'h0FF0, 1'b1);
    check("lit_basic_valid", out_valid, 1);
    check("lit_basic_op", op, 2);
    check("lit_basic_a", a, 16'h00F0);
    check("lit_basic_b", b, 16'h0FF0);
    cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    check("lit_basic_cnt", issue_count, 1);
    check("lit_basic_bad", bad_op, 0);

    // Backpressure
    txn(16'h0002, 16'h00F0, 16'h0FF0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 16'h5555, 1'b0, 1'b0, 1'b0);
    check("lit_bp_valid", out_valid, 1);
    check("lit_bp_ready", in_ready, 0);
    check("lit_bp_cnt", issue_count, 1);
    cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    check("lit_bp_cnt2", issue_count, 2);
    check("lit_bp_ready2", in_ready, 1);

    // Bad opcode, sticky through flush and a clean transaction
    txn(16'h8001, 16'h1234, 16'h5678, 1'b1);
    check("lit_bad_op", op, 1);
    check("lit_bad_flag", bad_op, 1);
    cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    txn(16'h0000, 16'h0001, 16'h0002, 1'b1);
    cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    check("lit_bad_sticky", bad_op, 1);

    // Flush mid-sequence together with the B word
    cyc(1'b1, 16'h0003, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 16'hAAAA, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 16'hBBBB, 1'b1, 1'b1, 1'b0);
    check("lit_flush_ready", in_ready, 1);
    txn(16'h0000, 16'h1111, 16'h2222, 1'b0);
    check("lit_flush_op", op, 0);
    check("lit_flush_a", a, 16'h1111);
    check("lit_flush_b", b, 16'h2222);

    // Flush in the issue state with out_ready high
    saved_cnt = int'(issue_count);
    cyc(1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
    check("lit_fissue_valid", out_valid, 0);
    check("lit_fissue_cnt", issue_count, saved_cnt);

    // Wrap at 256 issues with sustained 4-cycle throughput
    cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    check("lit_bad_cleared", bad_op, 0);
    tp_en = 1'b1;
    last_issue = -1;
    for (int i = 0; i < 1020; i++) cyc(1'b1, 16'($urandom_range(0, 3)), 1'b1, 1'b0, 1'b0);
    check("lit_wrap_255", issue_count, 8'hFF);
    for (int i = 0; i < 4; i++) cyc(1'b1, 16'h0001, 1'b1, 1'b0, 1'b0);
    check("lit_wrap_0", issue_count, 8'h00);
    tp_en = 1'b0;

    // Reset while waiting for B
    txn(16'h0001, 16'h7777, 16'h8888, 1'b1);
    cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 16'h8003, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'h4444, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'h9999, 1'b0, 1'b1, 1'b1);
    check("lit_rst_ready", in_ready, 1);
    check("lit_rst_valid", out_valid, 0);
    check("lit_rst_ab", {a, b}, 0);
    check("lit_rst_op", op, 0);
    check("lit_rst_bad", bad_op, 0);
    check("lit_rst_cnt", issue_count, 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] d;
      d = 16'($urandom);
      if ($urandom_range(0, 9) < 7) d[15:2] = '0;
      cyc(1'($urandom_range(0, 3) != 0), d, 1'($urandom_range(0, 2) != 0),
          1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 99) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
